shape_render_sched: RTL and testbench
=====================================

# shape_render_sched

Frame-level scheduler that sequences the shared polygon line scanner across all tangram pieces. On each frame request it walks the shape indices in order and skips pieces masked off. For each enabled piece it drives `shape_id` to the edge-lookup logic, pulses the scanner's start, and waits for the scanner's done pulse. It sits between the game/state logic (frame requests, visibility mask) and the single scanner + framebuffer writer.

## Interface
Parameters:
- `NSHAPE`, 7, number of drawable shapes (indices 0..NSHAPE-1)
- `SHAPEW`, 3, width of `shape_id`; must satisfy 2^SHAPEW > NSHAPE (index NSHAPE is reserved)

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_start` in 1: one-cycle request to render a frame.
- `shape_mask` in NSHAPE: bit i set = shape i drawn; sampled only when a frame is accepted.
- `scan_start` out 1: one-cycle start pulse to the scanner.
- `scan_done` in 1: one-cycle scanner completion pulse.
- `shape_id` out SHAPEW: shape currently selected for the scanner's x0/x1 lookup.
- `frame_busy` out 1: high from frame accept until `frame_done`.
- `frame_done` out 1: one-cycle pulse, frame complete.
- `overrun_cnt` out 8: saturating count of `frame_start` pulses rejected while busy.

## Operation
- States: IDLE, SEL, START, WAIT, DONE. All outputs are registered.
- IDLE:
  - On `frame_start`: latch `shape_mask` into `mask_q`, set index to the first index, set `frame_busy`=1, go to SEL.
  - The first index is 0, or NSHAPE with the config macro.
- SEL:
  - If index == END (past the last shape): go to DONE.
  - Else if the index is enabled: go to START.
  - Else: index+1 and stay in SEL. This costs one cycle per skipped shape.
  - Enabled means `mask_q[index]` for 0..NSHAPE-1; the clear index is always enabled.
- START: `scan_start`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold `shape_id` stable.
  - On `scan_done`: advance to the next index and go to SEL.
  - With the clear pass, index NSHAPE advances to 0.
- DONE: `frame_done`=1, `frame_busy`=0, go to IDLE.
- `shape_id` always equals the current index. END is encoded internally and is never driven onto `shape_id`.
- `frame_start` while not in IDLE:
  - Ignored.
  - `overrun_cnt` increments and saturates at 255.
  - The frame in progress is unaffected.
- `scan_done` outside WAIT: ignored.
- `shape_mask` changes mid-frame: no effect, because `mask_q` is only written in IDLE.
- Reset (`rst_n`=0 at a clock edge), from any state:
  - state=IDLE, `scan_start`=0, `frame_busy`=0, `frame_done`=0, `shape_id`=0, `overrun_cnt`=0, `mask_q`=0.
  - A scanner pass in flight is abandoned. The scanner shares the same reset, so both sides restart clean.

## Timing
- `frame_start` sampled at edge T0 gives state SEL in cycle T0+1.
- If the first index is enabled, `scan_start` is high in cycle T0+2.
- A `scan_done` sampled at edge Td gives SEL in cycle Td+1. If the next index is enabled, the next `scan_start` is in cycle Td+2.
- Per drawn shape: 2 cycles of overhead plus the scanner time.
- Per skipped shape: 1 cycle.
- From the last `scan_done` at Td: SEL→END in cycle Td+1, `frame_done` in cycle Td+2, IDLE in cycle Td+3.
- `shape_mask`=0 and no clear pass: the frame lasts cycles T0+1..T0+NSHAPE+2, and `frame_done` is high in cycle T0+NSHAPE+2.
- `frame_start` in the same cycle as `frame_done`: rejected and counted. A new frame is accepted only once the state is IDLE (cycle Td+3 onward).

## Configuration
- Macro: `SHAPE_RENDER_SCHED_CLEAR_EN`.
- Defined: each frame begins with a background-clear pass.
  - `shape_id`=NSHAPE, one `scan_start`/`scan_done` handshake, run regardless of mask.
  - Then indices 0..NSHAPE-1 follow as normal.
- Undefined:
  - No clear pass; the first index is 0.
  - Index NSHAPE is never driven.

## Test plan
- Reset/all-enabled: hold `rst_n`=0 for 3 cycles and check all outputs are 0. Release, then send `frame_start` with mask=7'h7F and a scanner model answering `scan_done` 10 cycles after each start → 7 `scan_start` pulses with `shape_id` 0..6 in order, then one `frame_done`.
- Sparse mask 7'b1000101 → `scan_start` only for ids 0, 2, 6. The gap between the done for id 0 and the start for id 2 is 3 cycles (SEL skips id 1).
- Empty mask 7'h00 (macro undefined) → no `scan_start`; `frame_done` in cycle T0+9; `frame_busy` high for cycles T0+1..T0+8.
- Overrun: 300 `frame_start` pulses during one busy frame → `overrun_cnt`=255 and the frame completes normally. Spurious `scan_done` in SEL or IDLE → no state change.
- Mid-frame: change mask and pulse reset. Flip mask from 7'h7F to 7'h01 during shape 2 → shapes 3..6 are still drawn. Assert `rst_n`=0 in WAIT → IDLE next cycle, `frame_busy`=0, `shape_id`=0, no `frame_done`.
- With `SHAPE_RENDER_SCHED_CLEAR_EN` and mask 7'h01 → `shape_id`=7 pass first, then id 0, then `frame_done`.

Source files
------------

// File: rtl/shape_render_sched.sv
// shape_render_sched: frame-level scheduler for the shared polygon line scanner.
// Walks the shape indices in order, skips masked-off pieces, and for each drawn
// piece presents shape_id, pulses scan_start and waits for scan_done.
// Optional feature macro: SHAPE_RENDER_SCHED_CLEAR_EN -- when defined, each frame
// starts with a background-clear pass on shape_id == NSHAPE before index 0.
//
// Handshake: scan_start is a one-cycle request; the scanner answers with a
// one-cycle scan_done, which is only honoured while waiting (WAIT state).
// frame_start is a one-cycle request accepted only in IDLE; any other cycle it
// is rejected and counted in the saturating overrun_cnt.
module shape_render_sched #(
  parameter int NSHAPE = 7,
  parameter int SHAPEW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [NSHAPE-1:0] shape_mask,
  output logic              scan_start,
  input  logic              scan_done,
  output logic [SHAPEW-1:0] shape_id,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [SHAPEW-1:0] LAST_ID  = SHAPEW'(NSHAPE - 1);
`ifdef SHAPE_RENDER_SCHED_CLEAR_EN
  localparam logic [SHAPEW-1:0] CLEAR_ID = SHAPEW'(NSHAPE);
  localparam logic [SHAPEW-1:0] FIRST_ID = CLEAR_ID;
`else
  localparam logic [SHAPEW-1:0] FIRST_ID = '0;
`endif

  state_e              state_q, state_d;
  logic [SHAPEW-1:0]   shape_id_q, shape_id_d;
  logic                end_q, end_d;        // index has run past the last shape
  logic [NSHAPE-1:0]   mask_q, mask_d;
  logic                scan_start_q, scan_start_d;
  logic                frame_busy_q, frame_busy_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          overrun_q, overrun_d;

  logic [(1<<SHAPEW)-1:0] en_vec;
  logic [SHAPEW-1:0]      nxt_id;
  logic                   nxt_end;
  logic                   advance;

  // Per-index enable: latched mask for real shapes, the clear index always on.
  always_comb begin
    en_vec             = '0;
    en_vec[NSHAPE-1:0] = mask_q;
    en_vec[NSHAPE]     = 1'b1;
  end

  // Successor of the current index; END is a flag so shape_id keeps the last id.
  always_comb begin
    nxt_id  = shape_id_q + 1'b1;
    nxt_end = 1'b0;
    if (shape_id_q == LAST_ID) begin
      nxt_id  = shape_id_q;
      nxt_end = 1'b1;
    end
`ifdef SHAPE_RENDER_SCHED_CLEAR_EN
    if (shape_id_q == CLEAR_ID) begin
      nxt_id  = '0;
      nxt_end = 1'b0;
    end
`endif
  end

  // Next-state and registered-output logic for the frame walk.
  always_comb begin
    state_d      = state_q;
    shape_id_d   = shape_id_q;
    end_d        = end_q;
    mask_d       = mask_q;
    scan_start_d = 1'b0;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    advance      = 1'b0;

    if (frame_start && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mask_d       = shape_mask;
          shape_id_d   = FIRST_ID;
          end_d        = 1'b0;
          frame_busy_d = 1'b1;
          state_d      = S_SEL;
        end
      end
      S_SEL: begin
        if (end_q) begin
          frame_done_d = 1'b1;
          frame_busy_d = 1'b0;
          state_d      = S_DONE;
        end else if (en_vec[shape_id_q]) begin
          scan_start_d = 1'b1;
          state_d      = S_START;
        end else begin
          advance = 1'b1;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (scan_done) begin
          advance = 1'b1;
          state_d = S_SEL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      shape_id_d = nxt_id;
      end_d      = nxt_end;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shape_id_q   <= '0;
      end_q        <= 1'b0;
      mask_q       <= '0;
      scan_start_q <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      shape_id_q   <= shape_id_d;
      end_q        <= end_d;
      mask_q       <= mask_d;
      scan_start_q <= scan_start_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign scan_start  = scan_start_q;
  assign shape_id    = shape_id_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign overrun_cnt = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shape_render_sched.sv
// Testbench for shape_render_sched: scanner responder with per-pass latencies,
// start/done monitor, and a frame-level timing model built from the schedule rules.
module tb_shape_render_sched;
  localparam int NSHAPE = 7;
  localparam int SHAPEW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [NSHAPE-1:0] shape_mask;
  logic              scan_start;
  logic              scan_done;
  logic              model_done = 1'b0;
  logic              spurious_done;
  logic [SHAPEW-1:0] shape_id;
  logic              frame_busy;
  logic              frame_done;
  logic [7:0]        overrun_cnt;
  logic [2:0]        dbg_state;

  assign scan_done = model_done | spurious_done;

  shape_render_sched #(.NSHAPE(NSHAPE), .SHAPEW(SHAPEW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .shape_mask  (shape_mask),
    .scan_start  (scan_start),
    .scan_done   (scan_done),
    .shape_id    (shape_id),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard storage
  logic [SHAPEW-1:0] obs_id_q[$];
  int                obs_cyc_q[$];
  int                lat_arr[1024];
  int                pend = 0;
  int                n_starts = 0;
  int                n_done = 0;
  int                n_busy = 0;
  int                done_cyc = 0;
  logic [SHAPEW-1:0] exp_id_q[$];
  int                exp_cyc_q[$];
  int                exp_done_cyc;
  int                n_cmp = 0;
  int                n_err = 0;
  int                e0, lat_base, id_base, done_base, busy_base;
  logic [2:0]        idle_state;

  // scanner responder and monitor, sampled on the falling edge
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) model_done = 1'b1;
      end
      if (scan_start) begin
        obs_id_q.push_back(shape_id);
        obs_cyc_q.push_back(cyc);
        pend = lat_arr[n_starts];
        n_starts++;
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (frame_busy) n_busy++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected starts and frame_done cycle: each drawn index costs SEL+START+latency,
  // each skipped index one SEL cycle, then one SEL at the end and the DONE cycle.
  task automatic model_frame(input logic [NSHAPE-1:0] m);
    int seq[$];
    int t;
    int k;
    logic [NSHAPE:0] draw;
    draw = {1'b1, m};
    exp_id_q  = {};
    exp_cyc_q = {};
`ifdef SHAPE_RENDER_SCHED_CLEAR_EN
    seq.push_back(NSHAPE);
`endif
    for (int i = 0; i < NSHAPE; i++) seq.push_back(i);
    t = e0;
    k = 0;
    foreach (seq[j]) begin
      if (draw[seq[j]]) begin
        exp_id_q.push_back(SHAPEW'(seq[j]));
        exp_cyc_q.push_back(t + 1);
        t += 2 + lat_arr[lat_base + k];
        k++;
      end else begin
        t += 1;
      end
    end
    exp_done_cyc = t + 1;
  endtask

  // lat_fixed == 0 selects a random scanner latency per pass
  task automatic start_frame(input logic [NSHAPE-1:0] m, input int lat_fixed);
    lat_base = n_starts;
    for (int k = 0; k <= NSHAPE; k++)
      lat_arr[lat_base + k] = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12));
    id_base     = obs_id_q.size();
    done_base   = n_done;
    busy_base   = n_busy;
    shape_mask  = m;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    e0 = cyc;
    model_frame(m);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (n_done == done_base && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic check_frame(input string tag);
    int n_obs;
    tick();
    tick();
    n_obs = obs_id_q.size() - id_base;
    check({tag, "_nstart"}, n_obs, exp_id_q.size());
    for (int i = 0; i < exp_id_q.size() && i < n_obs; i++) begin
      check({tag, "_id"}, obs_id_q[id_base + i], exp_id_q[i]);
      check({tag, "_start_cyc"}, obs_cyc_q[id_base + i], exp_cyc_q[i]);
    end
    check({tag, "_ndone"}, n_done - done_base, 1);
    check({tag, "_done_cyc"}, done_cyc, exp_done_cyc);
    check({tag, "_busy_cycles"}, n_busy - busy_base, exp_done_cyc - e0);
    check({tag, "_idle_state"}, dbg_state, idle_state);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int starts0;
    int done0;
    rst_n         = 1'b0;
    frame_start   = 1'b0;
    shape_mask    = '0;
    spurious_done = 1'b0;

    // reset held 3 cycles
    tick(); tick(); tick();
    check("rst_scan_start", scan_start, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_shape_id", shape_id, 0);
    check("rst_overrun", overrun_cnt, 0);
    idle_state = dbg_state;
    rst_n = 1'b1;
    tick();

    // all shapes enabled, 10-cycle scanner
    start_frame(7'h7F, 10);
    wait_done();
    check_frame("all");

    // sparse mask: ids 0, 2, 6
    start_frame(7'b1000101, 10);
    wait_done();
    check_frame("sparse");

    // empty mask
    start_frame(7'h00, 1);
    wait_done();
    check_frame("empty");

    // spurious scan_done while idle
    starts0 = n_starts;
    spurious_done = 1'b1;
    tick();
    spurious_done = 1'b0;
    tick();
    check("spur_idle_busy", frame_busy, 0);
    check("spur_idle_starts", n_starts - starts0, 0);

    // spurious scan_done while walking SEL
    start_frame(7'h00, 1);
    spurious_done = 1'b1;
    tick();
    spurious_done = 1'b0;
    wait_done();
    check_frame("spur_sel");

    // random masks and scanner latencies
    for (int r = 0; r < 6; r++) begin
      start_frame(NSHAPE'($urandom_range(0, (1 << NSHAPE) - 1)), 0);
      wait_done();
      check_frame("rand");
    end

    // mask changed while shape 2 is being drawn
    start_frame(7'h7F, 10);
    guard = 0;
    while (obs_id_q.size() < id_base + 3 && guard < 1000) begin
      tick();
      guard++;
    end
    shape_mask = 7'h01;
    wait_done();
    check_frame("mask_flip");

    // 300 rejected requests during one busy frame
    start_frame(7'h7F, 50);
    for (int i = 0; i < 300; i++) begin
      frame_start = 1'b1;
      tick();
    end
    frame_start = 1'b0;
    wait_done();
    check("overrun_sat", overrun_cnt, 255);
    check_frame("overrun");

    // reset while waiting on the scanner
    start_frame(7'h7F, 10);
    guard = 0;
    while (obs_id_q.size() < id_base + 2 && guard < 1000) begin
      tick();
      guard++;
    end
    tick(); tick(); tick();
    done0   = n_done;
    rst_n   = 1'b0;
    tick();
    check("rstw_busy", frame_busy, 0);
    check("rstw_shape_id", shape_id, 0);
    check("rstw_scan_start", scan_start, 0);
    check("rstw_frame_done", frame_done, 0);
    check("rstw_overrun", overrun_cnt, 0);
    check("rstw_idle_state", dbg_state, idle_state);
    rst_n   = 1'b1;
    starts0 = n_starts;
    for (int i = 0; i < 20; i++) tick();
    check("rstw_no_done", n_done - done0, 0);
    check("rstw_no_start", n_starts - starts0, 0);

    // request in the frame_done cycle is rejected and counted
    start_frame(NSHAPE'($urandom_range(1, (1 << NSHAPE) - 1)), 0);
    wait_done();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("donecyc_overrun", overrun_cnt, 1);
    check("donecyc_busy", frame_busy, 0);
    starts0 = n_starts;
    tick();
    check("donecyc_busy2", frame_busy, 0);
    check_frame("donecyc");
    check("donecyc_no_start", n_starts - starts0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
